// File: rtl/varredura_matriz_leds.sv
// varredura_matriz_leds
// Row-scan controller for an 8x8 LED matrix. It accepts a 64-bit image
// through a valid/ready handshake and keeps it in a pending buffer. It
// time-multiplexes the active image onto the row/column pins one row at a
// time. A pending image becomes active only at a frame boundary, so a
// displayed frame never mixes rows from two images.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       1 = scan running, 0 = matrix dark
//   frame_in     image, bit 8*r+c = LED at row r, column c (1 = lit)
//   frame_valid  frame_in is valid
//   frame_ready  pending buffer empty; transfer on valid && ready
//   linhas       one-hot row select at LINE_ACTIVE_HIGH polarity
//   colunas      column data of the selected row at COL_ACTIVE_HIGH polarity
//   frame_done   one-cycle pulse once row 7 blanking has finished
//   db_linha     current row index (debug)
//
// Each row slot is one CARREGA cycle, then ROW_TICKS cycles of EXIBE, then
// BLANK_TICKS cycles of APAGA. A frame therefore lasts
// 8*(1+ROW_TICKS+BLANK_TICKS) cycles. Only the CARREGA slot in front of
// row 0 is a frame boundary.
module varredura_matriz_leds #(
    parameter int ROW_TICKS        = 1000,
    parameter int BLANK_TICKS      = 10,
    parameter bit LINE_ACTIVE_HIGH = 1'b1,
    parameter bit COL_ACTIVE_HIGH  = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [7:0]  linhas,
    output logic [7:0]  colunas,
    output logic        frame_done,
    output logic [2:0]  db_linha
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] ROW_LAST   = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [7:0] LINE_OFF = LINE_ACTIVE_HIGH ? 8'h00 : 8'hFF;
    localparam logic [7:0] COL_OFF  = COL_ACTIVE_HIGH  ? 8'h00 : 8'hFF;

    typedef enum logic [1:0] {
        OCIOSO,
        CARREGA,
        EXIBE,
        APAGA
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [63:0]   active_q, active_d;
    logic [63:0]   pending_q, pending_d;
    logic          pending_full_q, pending_full_d;
    logic          frame_ready_q, frame_ready_d;
    logic [7:0]    linhas_q, linhas_d;
    logic [7:0]    colunas_q, colunas_d;
    logic          frame_done_q, frame_done_d;
    logic [2:0]    db_linha_q, db_linha_d;
    logic          load_frame;
    logic          accept;
    logic [7:0]    row_sel;
    logic [7:0]    row_bits;

    // Next-state and next-output computation. The registered outputs are
    // derived from the next state. This keeps the pins aligned with the
    // state they describe, without a cycle of lag.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = 1'b0;
        load_frame     = 1'b0;
        accept         = frame_valid && frame_ready_q;

        case (state_q)
            OCIOSO: begin
                if (enable) begin
                    state_d    = CARREGA;
                    row_d      = 3'd0;
                    load_frame = 1'b1;
                end
            end
            CARREGA: state_d = EXIBE;
            EXIBE: begin
                if (tick_q == ROW_LAST) begin
                    state_d = (BLANK_TICKS == 0) ? CARREGA : APAGA;
                end
            end
            APAGA: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = CARREGA;
                end
            end
            default: state_d = OCIOSO;
        endcase

        // Leaving a row: step to the next row. When row 7 ends, wrap to
        // row 0, which marks a frame boundary.
        if ((state_q == EXIBE || state_q == APAGA) && state_d == CARREGA) begin
            if (row_q == 3'd7) begin
                row_d        = 3'd0;
                frame_done_d = 1'b1;
                load_frame   = 1'b1;
            end else begin
                row_d = row_q + 3'd1;
            end
        end

        // Disabling the scan overrides everything. The image buffers are kept.
        if (!enable) begin
            state_d      = OCIOSO;
            row_d        = 3'd0;
            frame_done_d = 1'b0;
            load_frame   = 1'b0;
        end

        // The swap is committed on the edge that enters the boundary CARREGA
        // cycle. This means frame_ready is already high during that cycle.
        // The swap looks only at the pending_full from before this edge, so
        // a word accepted on the same edge waits for the next boundary.
        if (load_frame && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = frame_in;
            pending_full_d = 1'b1;
        end

        tick_d = (state_d != state_q || state_d == OCIOSO) ? '0 : tick_q + 1'b1;

        row_sel  = 8'd1 << row_d;
        row_bits = active_d[{row_d, 3'b000} +: 8];

        linhas_d  = LINE_OFF;
        colunas_d = COL_OFF;
        if (state_d == EXIBE) begin
            linhas_d  = LINE_ACTIVE_HIGH ? row_sel : ~row_sel;
            colunas_d = COL_ACTIVE_HIGH ? row_bits : ~row_bits;
        end
        frame_ready_d = !pending_full_d;
        db_linha_d    = row_d;
    end

    // State, buffers and output registers, all cleared by the async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= OCIOSO;
            row_q          <= 3'd0;
            tick_q         <= '0;
            active_q       <= 64'd0;
            pending_q      <= 64'd0;
            pending_full_q <= 1'b0;
            frame_ready_q  <= 1'b1;
            linhas_q       <= LINE_OFF;
            colunas_q      <= COL_OFF;
            frame_done_q   <= 1'b0;
            db_linha_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            tick_q         <= tick_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_ready_q  <= frame_ready_d;
            linhas_q       <= linhas_d;
            colunas_q      <= colunas_d;
            frame_done_q   <= frame_done_d;
            db_linha_q     <= db_linha_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign linhas      = linhas_q;
    assign colunas     = colunas_q;
    assign frame_done  = frame_done_q;
    assign db_linha    = db_linha_q;

endmodule

// File: tb/tb_varredura_matriz_leds.sv
module tb_varredura_matriz_leds;

   localparam int ROW_T  = 4;
   localparam int BLANK_T = 1;
   localparam int ROWP   = 1 + ROW_T + BLANK_T;
   localparam int FRAME  = 8 * ROWP;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [63:0] frame_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [7:0]  linhas;
   logic [7:0]  colunas;
   logic        frame_done;
   logic [2:0]  db_linha;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: the scan position within a frame, the two images and
   // the pending flag.
   bit          mRun;
   int          mPos;
   logic [63:0] mAct;
   logic [63:0] mPend;
   bit          mPfull;
   bit          mDone;

   varredura_matriz_leds #(
      .ROW_TICKS(ROW_T),
      .BLANK_TICKS(BLANK_T),
      .LINE_ACTIVE_HIGH(1'b1),
      .COL_ACTIVE_HIGH(1'b0)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .frame_in(frame_in),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .linhas(linhas),
      .colunas(colunas),
      .frame_done(frame_done),
      .db_linha(db_linha)
   );

   always #5 clock = ~clock;

   // Clears the reference model to its power-on state.
   task automatic modelReset();
      mRun = 0; mPos = 0; mAct = '0; mPend = '0; mPfull = 0; mDone = 0;
   endtask

   // Advances the reference model by one rising edge, using the inputs present at that edge.
   task automatic modelEdge();
      bit acc;
      acc = frame_valid && !mPfull;
      mDone = 0;
      if (reset) begin
         modelReset();
      end else begin
         if (!enable) begin
            mRun = 0; mPos = 0;
         end else if (!mRun) begin
            mRun = 1; mPos = 0;
            if (mPfull) begin mAct = mPend; mPfull = 0; end
         end else if (mPos == FRAME - 1) begin
            mPos = 0; mDone = 1;
            if (mPfull) begin mAct = mPend; mPfull = 0; end
         end else begin
            mPos++;
         end
         if (acc) begin mPend = frame_in; mPfull = 1; end
      end
   endtask

   // Advances one clock, updates the model, then leaves time for the outputs to settle.
   task automatic applyStimulus();
      @(posedge clock);
      modelEdge();
      #1;
   endtask

   function automatic bit expLit();
      int ph;
      ph = mPos % ROWP;
      return mRun && ph >= 1 && ph <= ROW_T;
   endfunction

   function automatic logic [7:0] expLinhas();
      logic [7:0] one;
      one = 8'd1;
      return expLit() ? (one << (mPos / ROWP)) : 8'h00;
   endfunction

   function automatic logic [7:0] expColunas();
      int r;
      r = mPos / ROWP;
      return expLit() ? ~mAct[8*r +: 8] : 8'hFF;
   endfunction

   function automatic logic [2:0] expDb();
      return mRun ? 3'(mPos / ROWP) : 3'd0;
   endfunction

   // Reset values after a clean reset release.
   task automatic test_reset();
      reset = 1; enable = 0; frame_valid = 0; frame_in = '0;
      modelReset();
      repeat (3) applyStimulus();
      @(negedge clock); reset = 0;
      applyStimulus();
      tests_run++; if (linhas !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_linhas: got %h expected 00", linhas); end
      tests_run++; if (colunas !== 8'hFF) begin tests_failed++; $display("[TB] FAIL reset_colunas: got %h expected ff", colunas); end
      tests_run++; if (frame_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", frame_ready); end
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
      tests_run++; if (db_linha !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_db: got %0d expected 0", db_linha); end
   endtask

   // Blank image scan: row sequence, dark columns and the frame_done period.
   task automatic test_idle_scan();
      int firstDone, secondDone;
      firstDone = -1; secondDone = -1;
      enable = 1;
      for (int c = 0; c < 100; c++) begin
         applyStimulus();
         tests_run++; if (linhas !== expLinhas()) begin tests_failed++; $display("[TB] FAIL idle_linhas c=%0d: got %h expected %h", c, linhas, expLinhas()); end
         tests_run++; if (colunas !== 8'hFF) begin tests_failed++; $display("[TB] FAIL idle_colunas c=%0d: got %h expected ff", c, colunas); end
         tests_run++; if (frame_done !== mDone) begin tests_failed++; $display("[TB] FAIL idle_done c=%0d: got %b expected %b", c, frame_done, mDone); end
         tests_run++; if (!$onehot0(linhas)) begin tests_failed++; $display("[TB] FAIL idle_onehot c=%0d: got %h expected at most one bit", c, linhas); end
         if (frame_done === 1'b1) begin
            if (firstDone < 0) firstDone = c;
            else if (secondDone < 0) secondDone = c;
         end
      end
      tests_run++;
      if (firstDone < 0 || secondDone - firstDone != FRAME) begin
         tests_failed++; $display("[TB] FAIL idle_period: got %0d expected %0d", secondDone - firstDone, FRAME);
      end
      enable = 0;
      applyStimulus();
      tests_run++; if (linhas !== 8'h00) begin tests_failed++; $display("[TB] FAIL idle_off: got %h expected 00", linhas); end
   endtask

   // Diagonal image loaded while idle, then shown.
   task automatic test_diagonal();
      logic [7:0] one, want;
      one = 8'd1;
      frame_in = 64'h8040201008040201; frame_valid = 1;
      applyStimulus();
      frame_valid = 0;
      tests_run++; if (frame_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL diag_ready_low: got %b expected 0", frame_ready); end
      enable = 1;
      applyStimulus();
      tests_run++; if (frame_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL diag_ready_swap: got %b expected 1", frame_ready); end
      for (int c = 0; c < FRAME; c++) begin
         applyStimulus();
         tests_run++; if (linhas !== expLinhas()) begin tests_failed++; $display("[TB] FAIL diag_linhas c=%0d: got %h expected %h", c, linhas, expLinhas()); end
         if (expLit()) begin
            want = ~(one << (mPos / ROWP));
            tests_run++; if (colunas !== want) begin tests_failed++; $display("[TB] FAIL diag_colunas c=%0d: got %h expected %h", c, colunas, want); end
         end
      end
   endtask

   // A second frame offered mid-scan is only shown after the frame boundary.
   task automatic test_second_frame();
      logic [63:0] f2;
      bit seen;
      for (int k = 0; k < 2 * FRAME && !(mRun && mPos == 20); k++) applyStimulus();
      tests_run++; if (!(mRun && mPos == 20)) begin tests_failed++; $display("[TB] FAIL second_reach: got pos %0d expected 20", mPos); end
      f2 = {$urandom, $urandom};
      frame_in = f2; frame_valid = 1;
      applyStimulus();
      frame_valid = 0; frame_in = '0;
      tests_run++; if (frame_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL second_ready_low: got %b expected 0", frame_ready); end
      seen = 0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
         applyStimulus();
         tests_run++; if (colunas !== expColunas()) begin tests_failed++; $display("[TB] FAIL second_colunas: got %h expected %h", colunas, expColunas()); end
         if (mDone) begin
            seen = 1;
            tests_run++; if (frame_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL second_ready_back: got %b expected 1", frame_ready); end
         end
      end
      tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL second_timeout: got no frame_done expected one"); end
      applyStimulus();
      tests_run++; if (colunas !== ~f2[7:0]) begin tests_failed++; $display("[TB] FAIL second_show: got %h expected %h", colunas, ~f2[7:0]); end
   endtask

   // valid held while the pending buffer is full: no overwrite, accepted after the swap.
   task automatic test_back_to_back();
      logic [63:0] f3, f4;
      bit got;
      for (int k = 0; k < 2 * FRAME && mPos != 10; k++) applyStimulus();
      f3 = {$urandom, $urandom};
      f4 = ~f3;
      frame_in = f3; frame_valid = 1;
      applyStimulus();
      frame_in = f4;
      got = 0;
      for (int k = 0; k < 3 * FRAME && !got; k++) begin
         applyStimulus();
         tests_run++; if (frame_ready !== !mPfull) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %b expected %b", frame_ready, !mPfull); end
         tests_run++; if (colunas !== expColunas()) begin tests_failed++; $display("[TB] FAIL b2b_colunas: got %h expected %h", colunas, expColunas()); end
         if (mPfull && mPend == f4) got = 1;
      end
      frame_valid = 0;
      tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL b2b_timeout: got no accept expected one"); end
      applyStimulus();
      tests_run++; if (colunas !== ~f3[7:0]) begin tests_failed++; $display("[TB] FAIL b2b_show_f3: got %h expected %h", colunas, ~f3[7:0]); end
      for (int k = 0; k < 2 * FRAME && !mDone; k++) applyStimulus();
      applyStimulus();
      tests_run++; if (colunas !== ~f4[7:0]) begin tests_failed++; $display("[TB] FAIL b2b_show_f4: got %h expected %h", colunas, ~f4[7:0]); end
   endtask

   // Dropping enable during row 3 darkens the matrix, re-enable restarts at row 0.
   task automatic test_enable_drop();
      logic [63:0] img;
      for (int k = 0; k < 2 * FRAME && mPos != 3 * ROWP + 2; k++) applyStimulus();
      img = mAct;
      enable = 0;
      applyStimulus();
      tests_run++; if (linhas !== 8'h00) begin tests_failed++; $display("[TB] FAIL drop_linhas: got %h expected 00", linhas); end
      tests_run++; if (colunas !== 8'hFF) begin tests_failed++; $display("[TB] FAIL drop_colunas: got %h expected ff", colunas); end
      tests_run++; if (db_linha !== 3'd0) begin tests_failed++; $display("[TB] FAIL drop_db: got %0d expected 0", db_linha); end
      repeat (3) applyStimulus();
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_done: got %b expected 0", frame_done); end
      enable = 1;
      applyStimulus();
      tests_run++; if (linhas !== 8'h00) begin tests_failed++; $display("[TB] FAIL reen_load: got %h expected 00", linhas); end
      applyStimulus();
      tests_run++; if (linhas !== 8'h01) begin tests_failed++; $display("[TB] FAIL reen_linhas: got %h expected 01", linhas); end
      tests_run++; if (colunas !== ~img[7:0]) begin tests_failed++; $display("[TB] FAIL reen_colunas: got %h expected %h", colunas, ~img[7:0]); end
   endtask

   // Random enable/valid/frame traffic against the model.
   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         enable = ($urandom_range(0, 39) != 0);
         frame_valid = ($urandom_range(0, 3) == 0);
         frame_in = {$urandom, $urandom};
         applyStimulus();
         tests_run++; if (linhas !== expLinhas()) begin tests_failed++; $display("[TB] FAIL rand_linhas c=%0d: got %h expected %h", c, linhas, expLinhas()); end
         tests_run++; if (colunas !== expColunas()) begin tests_failed++; $display("[TB] FAIL rand_colunas c=%0d: got %h expected %h", c, colunas, expColunas()); end
         tests_run++; if (frame_ready !== !mPfull) begin tests_failed++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, frame_ready, !mPfull); end
         tests_run++; if (frame_done !== mDone) begin tests_failed++; $display("[TB] FAIL rand_done c=%0d: got %b expected %b", c, frame_done, mDone); end
         tests_run++; if (db_linha !== expDb()) begin tests_failed++; $display("[TB] FAIL rand_db c=%0d: got %0d expected %0d", c, db_linha, expDb()); end
      end
      enable = 1; frame_valid = 0;
   endtask

   // Asynchronous reset during row 5 returns everything to the reset values at once.
   task automatic test_reset_midscan();
      frame_in = {$urandom, $urandom}; frame_valid = 1;
      applyStimulus();
      frame_valid = 0;
      for (int k = 0; k < 3 * FRAME && !(mRun && mPos == 5 * ROWP + 2); k++) applyStimulus();
      tests_run++; if (linhas !== 8'h20) begin tests_failed++; $display("[TB] FAIL rst5_row: got %h expected 20", linhas); end
      reset = 1;
      #1;
      modelReset();
      tests_run++; if (linhas !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst5_linhas: got %h expected 00", linhas); end
      tests_run++; if (colunas !== 8'hFF) begin tests_failed++; $display("[TB] FAIL rst5_colunas: got %h expected ff", colunas); end
      tests_run++; if (frame_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst5_ready: got %b expected 1", frame_ready); end
      tests_run++; if (db_linha !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst5_db: got %0d expected 0", db_linha); end
      @(negedge clock); reset = 0;
      applyStimulus();
      applyStimulus();
      tests_run++; if (linhas !== 8'h01) begin tests_failed++; $display("[TB] FAIL rst5_restart: got %h expected 01", linhas); end
      tests_run++; if (colunas !== 8'hFF) begin tests_failed++; $display("[TB] FAIL rst5_blank: got %h expected ff", colunas); end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_diagonal();
      test_second_frame();
      test_back_to_back();
      test_enable_drop();
      test_random();
      test_reset_midscan();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
